// File: rtl/fetch_hazard_ctrl.sv
// IF-stage sequencing: load-use stalls, taken-branch redirects and halt handling.
// Control outputs are combinational from the registered state and live inputs.
module fetch_hazard_ctrl #(
    parameter int unsigned LOAD_LATENCY = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 MemRead_ID_EX,
    input  logic [4:0]           RD_ID_EX,
    input  logic [4:0]           RS1_IF_ID,
    input  logic [4:0]           RS2_IF_ID,
    input  logic                 branch_taken,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 PCSrc,
    output logic                 PC_write,
    output logic                 IF_ID_write,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_flush,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        StRun,
        StStall,
        StFlush,
        StHalt
    } state_e;

    localparam logic [3:0] StallReload = 4'(LOAD_LATENCY - 1);
    localparam logic [3:0] FlushReload = 4'(FLUSH_CYCLES - 1);
    localparam bit         StallMulti  = (LOAD_LATENCY > 1);
    localparam bit         FlushMulti  = (FLUSH_CYCLES > 1);

    state_e               state_q, state_d;
    logic [3:0]           dcnt_q, dcnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic                 hazard;

    assign hazard = MemRead_ID_EX && (RD_ID_EX != 5'd0) &&
                    ((RD_ID_EX == RS1_IF_ID) || (RD_ID_EX == RS2_IF_ID));

    always_comb begin
        PCSrc       = 1'b0;
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        halted      = 1'b0;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            StRun, StStall, StFlush: begin
                if (halt_req) begin
                    ID_EX_flush = 1'b1;
                    state_d     = StHalt;
                    dcnt_d      = 4'd0;
                end else if (branch_taken) begin
                    // Redirect; any pending stall or flush window is restarted.
                    PCSrc       = 1'b1;
                    PC_write    = 1'b1;
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                    flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
                    if (FlushMulti) begin
                        state_d = StFlush;
                        dcnt_d  = FlushReload;
                    end else begin
                        state_d = StRun;
                        dcnt_d  = 4'd0;
                    end
                end else if (state_q == StStall) begin
                    ID_EX_flush = 1'b1;
                    dcnt_d      = dcnt_q - 4'd1;
                    if (dcnt_q <= 4'd1) begin
                        state_d = StRun;
                        dcnt_d  = 4'd0;
                    end
                end else if (state_q == StFlush) begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_ID_flush = 1'b1;
                    dcnt_d      = dcnt_q - 4'd1;
                    if (dcnt_q <= 4'd1) begin
                        state_d = StRun;
                        dcnt_d  = 4'd0;
                    end
                end else if (hazard) begin
                    ID_EX_flush = 1'b1;
                    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
                    if (StallMulti) begin
                        state_d = StStall;
                        dcnt_d  = StallReload;
                    end
                end else begin
                    PC_write    = 1'b1;
                    IF_ID_write = 1'b1;
                end
            end
            StHalt: begin
                ID_EX_flush = 1'b1;
                halted      = 1'b1;
                if (resume && !halt_req) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                dcnt_d  = 4'd0;
            end
        endcase

        if (!reset) begin
            PCSrc       = 1'b0;
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            halted      = 1'b0;
            state_d     = StRun;
            dcnt_d      = 4'd0;
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end
    end

    // Reset values are folded into the next-state logic above.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        dcnt_q      <= dcnt_d;
        stall_cnt_q <= stall_cnt_d;
        flush_cnt_q <= flush_cnt_d;
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
